cc1200_spi_slave: RTL and testbench
===================================

# cc1200_spi_slave

SPI mode-0 responder implementing the CC1200 header/status/burst access protocol on the radio side of the link, oversampled by the local `clk`. It gives the FPGA SPI master a loopback and emulation target for bring-up, and has the same command set as the radio:
- register read/write, single and burst;
- command strobes;
- burst TX-FIFO write (header 0x7F);
- burst RX-FIFO read (header 0xFF).

The block sits between the board SPI pins, or the master's pins in loopback, and a user-side byte stream.

## Interface
- FIFO_DEPTH, 16, entries in each of the TX and RX FIFOs (power of two, ≥ 4)
- clk  in  1  system clock; must be ≥ 8× the SCLK frequency
- rstn  in  1  reset, asynchronous, active-low
- SCLK  in  1  SPI clock from master; idle low
- MOSI  in  1  master data; sampled on SCLK rising edge
- CS_n  in  1  chip select, active-low
- MISO  out  1  slave data; changes after SCLK falling edge; 0 while CS_n is high
- chip_state  in  3  value reported in status byte bits [6:4]
- strobe  out  1  one-clk pulse when a command strobe header completes
- strobe_addr  out  6  strobe address (0x30–0x3D), valid with `strobe`
- tx_data  out  8  head of TX FIFO (bytes written by the master)
- tx_valid  out  1  TX FIFO not empty
- tx_ready  in  1  pop TX FIFO when tx_valid && tx_ready
- rx_data  in  8  byte to queue for master reads
- rx_valid  in  1  push rx_data when !rx_full
- rx_full  out  1  RX FIFO full
- err_ovf  out  1  one-clk pulse: master wrote to a full TX FIFO
- err_unf  out  1  one-clk pulse: master read from an empty RX FIFO

## Operation
- **Input synchronisation.** SCLK, MOSI and CS_n each pass through a 2-flop synchroniser. Edge detection is done on the synchronised SCLK; MOSI is captured on the synchronised rising edge.
- **Header byte.**
  - bit7 = R/W (1 = read); bit6 = burst; bits[5:0] = address.
  - While the header shifts in, MISO carries the status byte {1'b0, chip_state, 4'b0000}.
  - chip_state is captured when the CS_n fall is detected.
- **Address map.**
  - 0x00–0x2F: internal 48×8 register file.
  - 0x30–0x3D: command strobes.
  - 0x3E: reserved; reads return 0x00 and writes are ignored.
  - 0x3F: FIFO. A write pushes the TX FIFO; a read pops the RX FIFO.
- **FSM states:** IDLE, HEADER, DATA, IGNORE.
  - IDLE → HEADER on a detected CS_n fall. The bit counter is cleared.
  - HEADER → on the 8th rising edge, the header is decoded:
    - strobe address: pulse `strobe`, then go to IGNORE;
    - any other address: go to DATA.
  - DATA handles each byte on its 8th rising edge:
    - **Write:** a register address stores the byte; address 0x3F pushes the TX FIFO, or pulses err_ovf and drops the byte if the FIFO is full.
    - **Read:** the next output byte is loaded at the 8th rising edge of the previous byte (header or data). A register address reads the array; address 0x3F pops the RX FIFO, or returns 0x00 and pulses err_unf if the FIFO is empty.
    - **Single access (burst = 0):** after the first data byte, go to IGNORE.
    - **Burst access:** a register address increments after each byte, wrapping 0x2F→0x00. The FIFO address stays at 0x3F.
  - IGNORE: MISO = 0; all MOSI bytes are discarded.
  - Any state → IDLE on a detected CS_n rise. A partial byte is discarded with no write, push or pop.
- **Register file.** All 48 registers reset to 0x00.
- **FIFOs.**
  - Each FIFO is FIFO_DEPTH × 8 with a count of log2(FIFO_DEPTH)+1 bits. Pointers wrap modulo FIFO_DEPTH.
  - TX FIFO: a user pop and an SPI push in the same clk are both performed.
  - RX FIFO: a user push and an SPI pop in the same clk are both performed. While the FIFO is full, a push is ignored unless a pop occurs in the same clk.
- **Reset values.** MISO = 0; strobe = 0; strobe_addr = 0; tx_valid = 0; tx_data = 0; rx_full = 0; err_ovf = 0; err_unf = 0. Both FIFOs are empty and the FSM is in IDLE.
- **Reset mid-transfer.** Everything returns to reset state. The transfer in progress is lost; the next CS_n fall starts a new header.

## Timing
- Synchroniser plus edge-detect latency is 3 clk from a pin edge to internal action.
- MISO:
  - The status MSB is driven within 3 clk of the CS_n fall.
  - Each subsequent bit updates within 3 clk of each SCLK fall.
  - Setup to the next SCLK rise is guaranteed when SCLK period ≥ 8 clk.
- Write, strobe and TX push occur 3 clk after the 8th SCLK rise of the byte.
- RX pop occurs 3 clk after the 8th SCLK rise of the preceding byte.
- tx_valid rises 1 clk after the push.
- rx_full updates 1 clk after the push or pop.

## Test plan
- **Single register write/read.** Write 0x05, 0xA5 (SCLK = clk/10), then read 0x85, 0x00. MISO returns status 0x20 (chip_state = 2) followed by 0xA5.
- **Burst write with wrap.** Burst-write header 0x6E with data 0x11, 0x22, 0x33. Registers 0x2E = 0x11, 0x2F = 0x22, 0x00 = 0x33. Burst read 0xEE returns 0x11, 0x22, 0x33.
- **TX FIFO burst with overflow.** Header 0x7F with 18 bytes 0x00..0x11, tx_ready = 0. tx_valid = 1, 16 bytes are stored, err_ovf pulses twice. Pops then yield 0x00..0x0F in order.
- **RX FIFO burst with underflow.** User pushes 0xC0, 0xC1, 0xC2; master reads 0xFF with 4 data bytes. MISO returns 0xC0, 0xC1, 0xC2, 0x00; err_unf pulses once.
- **Strobe.** Header 0x36 produces one strobe pulse with strobe_addr = 0x36. A following byte is ignored and MISO stays 0.
- **Abort and reset.**
  - CS_n rises after 4 bits of a write data byte: the register is unchanged and the next transaction decodes correctly.
  - rstn asserted mid-burst: all outputs return to reset values and the FIFOs are empty.

Source files
------------

// File: rtl/cc1200_spi_slave.sv
// CC1200-compatible SPI mode-0 responder: header/status protocol, 48-byte register
// file, command strobes and TX/RX byte FIFOs, all oversampled by clk.
module cc1200_spi_slave #(
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       SCLK,
    input  logic       MOSI,
    input  logic       CS_n,
    output logic       MISO,
    input  logic [2:0] chip_state,
    output logic       strobe,
    output logic [5:0] strobe_addr,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_full,
    output logic       err_ovf,
    output logic       err_unf
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL = {1'b1, {AW{1'b0}}};

    typedef enum logic [1:0] {IDLE, HEADER, DATA, IGNORE} state_t;

    logic [2:0] sclk_q, cs_q;
    logic [1:0] mosi_q;
    logic       sclk_rise, sclk_fall, cs_fall, cs_rise;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sclk_q <= '0;
            cs_q   <= '1;
            mosi_q <= '0;
        end else begin
            sclk_q <= {sclk_q[1:0], SCLK};
            cs_q   <= {cs_q[1:0], CS_n};
            mosi_q <= {mosi_q[0], MOSI};
        end
    end

    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall = ~sclk_q[1] & sclk_q[2];
    assign cs_fall   = ~cs_q[1] & cs_q[2];
    assign cs_rise   = cs_q[1] & ~cs_q[2];

    state_t     state;
    logic [2:0] bit_cnt;
    logic [6:0] shift_in;
    logic [7:0] shift_out;
    logic       miso_r, rw, burst, unf_pend;
    logic [5:0] addr;
    logic [7:0] regs [48];

    logic [7:0]    tx_mem [FIFO_DEPTH];
    logic [7:0]    rx_mem [FIFO_DEPTH];
    logic [AW-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
    logic [AW:0]   tx_cnt, rx_cnt;

    logic       byte_done, hdr_done, data_done, is_strobe, fetch;
    logic       reg_wr, tx_wr, tx_push, tx_pop, rx_push, rx_pop, rx_empty;
    logic [7:0] byte_in, fetch_byte;
    logic [5:0] next_addr;

    assign rx_empty = (rx_cnt == '0);
    assign tx_valid = (tx_cnt != '0);
    assign tx_data  = tx_valid ? tx_mem[tx_rp] : '0;
    assign rx_full  = (rx_cnt == FULL);
    assign tx_pop   = tx_valid & tx_ready;
    assign rx_push  = rx_valid & (~rx_full | rx_pop);
    assign MISO     = miso_r;

    always_comb begin
        byte_in    = {shift_in, mosi_q[1]};
        byte_done  = (state == HEADER || state == DATA) && sclk_rise && (bit_cnt == 3'd7) && !cs_rise;
        hdr_done   = byte_done && (state == HEADER);
        data_done  = byte_done && (state == DATA);
        is_strobe  = (byte_in[5:0] >= 6'h30) && (byte_in[5:0] <= 6'h3D);
        // next_addr is the address whose contents feed the byte shifted out next
        next_addr  = addr;
        if (hdr_done)
            next_addr = byte_in[5:0];
        else if (data_done && burst && addr < 6'd48)
            next_addr = (addr == 6'd47) ? '0 : addr + 6'd1;
        fetch      = (hdr_done && byte_in[7] && !is_strobe) || (data_done && rw && burst);
        reg_wr     = data_done && !rw && (addr < 6'd48);
        tx_wr      = data_done && !rw && (addr == 6'h3F);
        tx_push    = tx_wr && (tx_cnt != FULL);
        rx_pop     = fetch && (next_addr == 6'h3F) && !rx_empty;
        fetch_byte = '0;
        if (next_addr < 6'd48)
            fetch_byte = regs[next_addr];
        else if (rx_pop)
            fetch_byte = rx_mem[rx_rp];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            shift_in    <= '0;
            shift_out   <= '0;
            miso_r      <= 1'b0;
            rw          <= 1'b0;
            burst       <= 1'b0;
            addr        <= '0;
            unf_pend    <= 1'b0;
            strobe      <= 1'b0;
            strobe_addr <= '0;
            err_ovf     <= 1'b0;
            err_unf     <= 1'b0;
        end else begin
            strobe  <= 1'b0;
            err_ovf <= tx_wr && !tx_push;
            err_unf <= 1'b0;
            if (cs_rise) begin
                state    <= IDLE;
                miso_r   <= 1'b0;
                unf_pend <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (cs_fall) begin
                        state     <= HEADER;
                        bit_cnt   <= '0;
                        miso_r    <= 1'b0;
                        shift_out <= {chip_state, 5'b0};
                        unf_pend  <= 1'b0;
                    end
                    HEADER, DATA: begin
                        if (sclk_rise) begin
                            shift_in <= byte_in[6:0];
                            bit_cnt  <= bit_cnt + 3'd1;
                            // an empty-FIFO fetch only counts once the master clocks that byte
                            if (unf_pend && bit_cnt == 3'd0) begin
                                err_unf  <= 1'b1;
                                unf_pend <= 1'b0;
                            end
                        end
                        if (sclk_fall) begin
                            miso_r    <= shift_out[7];
                            shift_out <= {shift_out[6:0], 1'b0};
                        end
                        if (byte_done) begin
                            shift_out <= fetch ? fetch_byte : '0;
                            unf_pend  <= fetch && (next_addr == 6'h3F) && rx_empty;
                            if (hdr_done) begin
                                rw    <= byte_in[7];
                                burst <= byte_in[6];
                                addr  <= byte_in[5:0];
                                if (is_strobe) begin
                                    strobe      <= 1'b1;
                                    strobe_addr <= byte_in[5:0];
                                    state       <= IGNORE;
                                end else begin
                                    state <= DATA;
                                end
                            end else begin
                                addr <= next_addr;
                                if (!burst)
                                    state <= IGNORE;
                            end
                        end
                    end
                    IGNORE: miso_r <= 1'b0;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < 48; i++)
                regs[i] <= '0;
        end else if (reg_wr) begin
            regs[addr] <= byte_in;
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push)
            tx_mem[tx_wp] <= byte_in;
        if (rx_push)
            rx_mem[rx_wp] <= rx_data;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tx_wp  <= '0;
            tx_rp  <= '0;
            tx_cnt <= '0;
            rx_wp  <= '0;
            rx_rp  <= '0;
            rx_cnt <= '0;
        end else begin
            if (tx_push)
                tx_wp <= tx_wp + AW'(1);
            if (tx_pop)
                tx_rp <= tx_rp + AW'(1);
            if (tx_push && !tx_pop)
                tx_cnt <= tx_cnt + (AW + 1)'(1);
            else if (!tx_push && tx_pop)
                tx_cnt <= tx_cnt - (AW + 1)'(1);
            if (rx_push)
                rx_wp <= rx_wp + AW'(1);
            if (rx_pop)
                rx_rp <= rx_rp + AW'(1);
            if (rx_push && !rx_pop)
                rx_cnt <= rx_cnt + (AW + 1)'(1);
            else if (!rx_push && rx_pop)
                rx_cnt <= rx_cnt - (AW + 1)'(1);
        end
    end

endmodule

// File: tb/tb_cc1200_spi_slave.sv
// Directed bench for cc1200_spi_slave: drives SPI transactions and user-side FIFO
// traffic, checking against a transaction-level model of the radio's SPI protocol.
module tb_cc1200_spi_slave;
    localparam int DEPTH = 16;
    localparam int HALF  = 5;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       SCLK = 1'b0;
    logic       MOSI = 1'b0;
    logic       CS_n = 1'b1;
    logic       MISO;
    logic [2:0] chip_state = 3'd2;
    logic       strobe;
    logic [5:0] strobe_addr;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       rx_full, err_ovf, err_unf;

    always #5 clk = ~clk;

    cc1200_spi_slave #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rstn(rstn), .SCLK(SCLK), .MOSI(MOSI), .CS_n(CS_n), .MISO(MISO),
        .chip_state(chip_state), .strobe(strobe), .strobe_addr(strobe_addr),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_full(rx_full),
        .err_ovf(err_ovf), .err_unf(err_unf)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Model state: register file, FIFO contents and expected pulse counts
    logic [7:0] m_regs [48];
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    int exp_strobe = 0, exp_ovf = 0, exp_unf = 0;
    int n_strobe = 0, n_ovf = 0, n_unf = 0;
    logic [5:0] saddr = '0;
    bit chk_en = 1'b0;

    logic [7:0] mo [64];
    logic [7:0] mi [64];
    logic [7:0] me [64];

    always @(posedge clk) begin
        #1;
        if (strobe) begin
            n_strobe++;
            saddr = strobe_addr;
        end
        if (err_ovf) n_ovf++;
        if (err_unf) n_unf++;
        if (chk_en) begin
            check("tx_valid", tx_valid, tx_q.size() != 0);
            if (tx_q.size() != 0) check("tx_data", tx_data, tx_q[0]);
            else                  check("tx_data_empty", tx_data, 0);
            check("rx_full", rx_full, rx_q.size() == DEPTH);
            check("miso_idle", MISO, 0);
            check("strobe_idle", strobe, 0);
            check("err_ovf_idle", err_ovf, 0);
            check("err_unf_idle", err_unf, 0);
        end
    end

    task automatic check_reset(input string tag);
        check({tag, "_miso"}, MISO, 0);
        check({tag, "_strobe"}, strobe, 0);
        check({tag, "_strobe_addr"}, strobe_addr, 0);
        check({tag, "_tx_valid"}, tx_valid, 0);
        check({tag, "_tx_data"}, tx_data, 0);
        check({tag, "_rx_full"}, rx_full, 0);
        check({tag, "_err_ovf"}, err_ovf, 0);
        check({tag, "_err_unf"}, err_unf, 0);
    endtask

    // Mode-0 master: MOSI set while SCLK low, MISO sampled at each rising edge
    task automatic spi_xfer(input int nb, input int last_bits, input bit hold_cs);
        chk_en = 1'b0;
        @(negedge clk);
        CS_n = 1'b0;
        for (int i = 0; i < nb; i++) begin
            int nbits;
            nbits = (i == nb - 1) ? last_bits : 8;
            mi[i] = 8'h00;
            for (int b = 0; b < nbits; b++) begin
                MOSI = mo[i][7 - b];
                repeat (HALF) @(negedge clk);
                SCLK = 1'b1;
                mi[i] = {mi[i][6:0], MISO};
                repeat (HALF) @(negedge clk);
                SCLK = 1'b0;
            end
        end
        repeat (HALF) @(negedge clk);
        if (!hold_cs) begin
            CS_n = 1'b1;
            repeat (8) @(negedge clk);
        end
    endtask

    // Transaction-level protocol model over the nb fully-clocked bytes
    task automatic model_xfer(input int nb);
        logic [7:0] h;
        logic [5:0] a;
        bit rw, bst;
        h = mo[0];
        rw = h[7];
        bst = h[6];
        a = h[5:0];
        for (int i = 0; i < 64; i++) me[i] = 8'h00;
        me[0] = {1'b0, chip_state, 4'b0000};
        if (a >= 6'h30 && a <= 6'h3D) begin
            exp_strobe++;
            return;
        end
        for (int i = 1; i < nb; i++) begin
            if (i > 1 && !bst) break;
            if (rw) begin
                if (a < 6'd48) me[i] = m_regs[a];
                else if (a == 6'h3F) begin
                    if (rx_q.size() != 0) me[i] = rx_q.pop_front();
                    else exp_unf++;
                end
            end else begin
                if (a < 6'd48) m_regs[a] = mo[i];
                else if (a == 6'h3F) begin
                    if (tx_q.size() < DEPTH) tx_q.push_back(mo[i]);
                    else exp_ovf++;
                end
            end
            if (bst && a < 6'd48) a = (a == 6'd47) ? 6'd0 : a + 6'd1;
        end
        // a burst FIFO read has already fetched the byte after the last one clocked
        if (rw && bst && a == 6'h3F && nb > 1 && rx_q.size() != 0) void'(rx_q.pop_front());
    endtask

    task automatic txn(input string name, input int nb, input int last_bits);
        int ncomp;
        ncomp = (last_bits == 8) ? nb : nb - 1;
        spi_xfer(nb, last_bits, 1'b0);
        model_xfer(ncomp);
        for (int i = 0; i < ncomp; i++)
            check($sformatf("%s_miso%0d", name, i), mi[i], me[i]);
        check({name, "_strobe_cnt"}, n_strobe, exp_strobe);
        check({name, "_ovf_cnt"}, n_ovf, exp_ovf);
        check({name, "_unf_cnt"}, n_unf, exp_unf);
        chk_en = 1'b1;
    endtask

    task automatic rx_push(input logic [7:0] d);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data = d;
        if (rx_q.size() < DEPTH) rx_q.push_back(d);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic tx_pop(input logic [7:0] lit);
        @(negedge clk);
        check("tx_pop_data", tx_data, lit);
        tx_ready = 1'b1;
        void'(tx_q.pop_front());
        @(negedge clk);
        tx_ready = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 48; i++) m_regs[i] = 8'h00;
        repeat (3) @(negedge clk);
        check_reset("reset");
        rstn = 1'b1;
        repeat (4) @(negedge clk);
        chk_en = 1'b1;

        // Single register write then read back
        mo[0] = 8'h05; mo[1] = 8'hA5;
        txn("wr05", 2, 8);
        mo[0] = 8'h85; mo[1] = 8'h00;
        txn("rd05", 2, 8);
        check("rd05_status_lit", mi[0], 8'h20);
        check("rd05_data_lit", mi[1], 8'hA5);

        // Burst write across the 0x2F -> 0x00 wrap, then burst read back
        mo[0] = 8'h6E; mo[1] = 8'h11; mo[2] = 8'h22; mo[3] = 8'h33;
        txn("bwr", 4, 8);
        mo[0] = 8'hEE; mo[1] = 8'h00; mo[2] = 8'h00; mo[3] = 8'h00;
        txn("brd", 4, 8);
        check("brd_lit1", mi[1], 8'h11);
        check("brd_lit2", mi[2], 8'h22);
        check("brd_lit3", mi[3], 8'h33);

        // TX FIFO burst of 18 bytes into a 16-deep FIFO
        mo[0] = 8'h7F;
        for (int i = 0; i < 18; i++) mo[i + 1] = 8'(i);
        txn("txfifo", 19, 8);
        check("txfifo_ovf_lit", n_ovf, 2);
        check("txfifo_valid_lit", tx_valid, 1);
        for (int i = 0; i < 16; i++) tx_pop(8'(i));
        repeat (2) @(negedge clk);

        // RX FIFO burst read with underflow on the fourth byte
        rx_push(8'hC0); rx_push(8'hC1); rx_push(8'hC2);
        mo[0] = 8'hFF;
        for (int i = 1; i < 5; i++) mo[i] = 8'h00;
        txn("rxfifo", 5, 8);
        check("rxfifo_lit1", mi[1], 8'hC0);
        check("rxfifo_lit2", mi[2], 8'hC1);
        check("rxfifo_lit3", mi[3], 8'hC2);
        check("rxfifo_lit4", mi[4], 8'h00);
        check("rxfifo_unf_lit", n_unf, 1);

        // Strobe with a trailing ignored byte; chip_state changed to check capture
        chip_state = 3'd5;
        mo[0] = 8'h36; mo[1] = 8'hAB;
        txn("strobe", 2, 8);
        check("strobe_status_lit", mi[0], 8'h50);
        check("strobe_cnt_lit", n_strobe, 1);
        check("strobe_addr_lit", saddr, 6'h36);
        check("strobe_ignored_lit", mi[1], 8'h00);
        chip_state = 3'd2;

        // Abort after 4 bits of a write data byte, then confirm the register is intact
        mo[0] = 8'h05; mo[1] = 8'h5A;
        txn("abort", 2, 4);
        mo[0] = 8'h85; mo[1] = 8'h00;
        txn("abort_rd", 2, 8);
        check("abort_rd_lit", mi[1], 8'hA5);

        // Fill RX FIFO (17th push ignored), start a TX burst, reset mid-byte
        for (int i = 0; i < 17; i++) rx_push(8'hD0 + 8'(i));
        check("rx_full_lit", rx_full, 1);
        mo[0] = 8'h7F; mo[1] = 8'h99; mo[2] = 8'h98;
        spi_xfer(3, 4, 1'b1);
        check("midburst_tx_valid_lit", tx_valid, 1);
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        check_reset("midburst_rst");
        tx_q.delete();
        rx_q.delete();
        for (int i = 0; i < 48; i++) m_regs[i] = 8'h00;
        CS_n = 1'b1;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (4) @(negedge clk);
        chk_en = 1'b1;

        mo[0] = 8'h85; mo[1] = 8'h00;
        txn("post_rst_reg", 2, 8);
        check("post_rst_reg_lit", mi[1], 8'h00);
        mo[0] = 8'hFF; mo[1] = 8'h00;
        txn("post_rst_rx", 2, 8);
        check("post_rst_rx_lit", mi[1], 8'h00);

        repeat (4) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
